// File: rtl/byte_display_sequencer.sv
// Shows one captured byte on a single 7-segment digit: high nibble, low nibble
// with the decimal point lit, then an optional blank gap; supports repeat and abort.
module byte_display_sequencer #(
    parameter int unsigned DWELL_CYCLES = 1000000,
    parameter int unsigned GAP_CYCLES   = 250000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       load,
    output logic       ready,
    input  logic       repeat_en,
    input  logic       abort,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, HI, LO, GAP} state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shown;
    logic             pass_end;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign ready = (state == IDLE);

    // One display pass ends at the last GAP cycle, or at the last LO cycle when there is no gap.
    always_comb begin
        pass_end = ((state == GAP) && (cnt == GAP_LAST)) ||
                   ((state == LO) && (GAP_CYCLES == 0) && (cnt == DWELL_LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            shown <= '0;
            seg   <= '0;
            dp    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                state <= IDLE;
                cnt   <= '0;
                seg   <= '0;
                dp    <= 1'b0;
                busy  <= 1'b0;
            end else if (pass_end) begin
                cnt <= '0;
                dp  <= 1'b0;
                if (repeat_en) begin
                    state <= HI;
                    seg   <= hex7(shown[7:4]);
                end else begin
                    state <= IDLE;
                    seg   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (load) begin
                            shown <= data_in;
                            state <= HI;
                            cnt   <= '0;
                            seg   <= hex7(data_in[7:4]);
                            dp    <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                    HI: begin
                        if (cnt == DWELL_LAST) begin
                            state <= LO;
                            cnt   <= '0;
                            seg   <= hex7(shown[3:0]);
                            dp    <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    LO: begin
                        if (cnt == DWELL_LAST) begin
                            state <= GAP;
                            cnt   <= '0;
                            seg   <= '0;
                            dp    <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt <= cnt + CNT_W'(1);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_byte_display_sequencer.sv
// Randomized bench for byte_display_sequencer; expected outputs come from a
// per-cycle model indexed by cycles elapsed since the accepted load.
module tb_byte_display_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       load_a, load_b;
    logic       repeat_en, abort;
    logic       ready_a, ready_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, busy_a, busy_b, done_a, done_b;

    int checks   = 0;
    int failures = 0;

    localparam int DA = 4, GA = 2, DB = 3, GB = 0;
    localparam logic [10:0] IDLE_OUT = {7'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    byte_display_sequencer #(.DWELL_CYCLES(DA), .GAP_CYCLES(GA), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load_a), .ready(ready_a),
        .repeat_en(repeat_en), .abort(abort), .seg(seg_a), .dp(dp_a), .busy(busy_a), .done(done_a)
    );

    byte_display_sequencer #(.DWELL_CYCLES(DB), .GAP_CYCLES(GB), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load_b), .ready(ready_b),
        .repeat_en(repeat_en), .abort(abort), .seg(seg_b), .dp(dp_b), .busy(busy_b), .done(done_b)
    );

    // {seg, dp, busy, done, ready} k cycles after the accepting edge, for `passes` full passes.
    function automatic logic [10:0] model(input int k, input logic [7:0] b, input int d,
                                          input int g, input int passes);
        int p, total, r;
        p     = 2 * d + g;
        total = passes * p;
        if (k <= total) begin
            r = (k - 1) % p;
            if (r < d)          return {hex_tab[b[7:4]], 1'b0, 1'b1, 1'b0, 1'b0};
            else if (r < 2 * d) return {hex_tab[b[3:0]], 1'b1, 1'b1, 1'b0, 1'b0};
            else                return {7'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        end else if (k == total + 1) begin
            return {7'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        end
        return IDLE_OUT;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_a(input logic [7:0] b);
        data_in = b;
        load_a  = 1'b1;
        step();
        load_a  = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_a = 1'b1; load_b = 1'b1; data_in = 8'h5A;
        repeat_en = 1'b0; abort = 1'b0;
        step(); step();
        rst = 1'b0; load_a = 1'b0; load_b = 1'b0;
        checks++;
        if ({seg_a, dp_a, busy_a, done_a, ready_a} !== IDLE_OUT) begin
            failures++;
            $display("FAIL reset_a got=%h exp=%h", {seg_a, dp_a, busy_a, done_a, ready_a}, IDLE_OUT);
        end
        checks++;
        if ({seg_b, dp_b, busy_b, done_b, ready_b} !== IDLE_OUT) begin
            failures++;
            $display("FAIL reset_b got=%h exp=%h", {seg_b, dp_b, busy_b, done_b, ready_b}, IDLE_OUT);
        end
        step();
    endtask

    task automatic test_basic(input logic [7:0] b);
        logic [10:0] exp;
        accept_a(b);
        for (int k = 1; k <= 12; k++) begin
            exp = model(k, b, DA, GA, 1);
            checks++;
            if ({seg_a, dp_a, busy_a, done_a, ready_a} !== exp) begin
                failures++;
                $display("FAIL basic b=%h k=%0d got=%h exp=%h", b, k, {seg_a, dp_a, busy_a, done_a, ready_a}, exp);
            end
            step();
        end
    endtask

    task automatic test_load_ignored();
        logic [10:0] exp;
        accept_a(8'h3C);
        for (int k = 1; k <= 12; k++) begin
            exp = model(k, 8'h3C, DA, GA, 1);
            checks++;
            if ({seg_a, dp_a, busy_a, done_a, ready_a} !== exp) begin
                failures++;
                $display("FAIL load_ignored k=%0d got=%h exp=%h", k, {seg_a, dp_a, busy_a, done_a, ready_a}, exp);
            end
            load_a  = (k == 3);
            data_in = 8'hFF;
            step();
        end
        load_a = 1'b0;
    endtask

    task automatic test_repeat();
        logic [10:0] exp;
        logic [7:0]  b;
        b = 8'h05;
        repeat_en = 1'b1;
        accept_a(b);
        for (int k = 1; k <= 23; k++) begin
            exp = model(k, b, DA, GA, 2);
            checks++;
            if ({seg_a, dp_a, busy_a, done_a, ready_a} !== exp) begin
                failures++;
                $display("FAIL repeat k=%0d got=%h exp=%h", k, {seg_a, dp_a, busy_a, done_a, ready_a}, exp);
            end
            if (k == 15) repeat_en = 1'b0;
            step();
        end
    endtask

    task automatic test_abort();
        logic [10:0] exp;
        logic [7:0]  b2;
        accept_a(8'h12);
        for (int k = 1; k <= 6; k++) begin
            exp = model(k, 8'h12, DA, GA, 1);
            checks++;
            if ({seg_a, dp_a, busy_a, done_a, ready_a} !== exp) begin
                failures++;
                $display("FAIL abort_pre k=%0d got=%h exp=%h", k, {seg_a, dp_a, busy_a, done_a, ready_a}, exp);
            end
            if (k < 6) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({seg_a, dp_a, busy_a, done_a, ready_a} !== IDLE_OUT) begin
            failures++;
            $display("FAIL abort_idle got=%h exp=%h", {seg_a, dp_a, busy_a, done_a, ready_a}, IDLE_OUT);
        end
        b2 = 8'($urandom);
        accept_a(b2);
        for (int k = 1; k <= 12; k++) begin
            exp = model(k, b2, DA, GA, 1);
            checks++;
            if ({seg_a, dp_a, busy_a, done_a, ready_a} !== exp) begin
                failures++;
                $display("FAIL abort_reload k=%0d got=%h exp=%h", k, {seg_a, dp_a, busy_a, done_a, ready_a}, exp);
            end
            step();
        end
    endtask

    task automatic test_gap0(input logic [7:0] b);
        logic [10:0] exp;
        data_in = b;
        load_b  = 1'b1;
        step();
        load_b  = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            exp = model(k, b, DB, GB, 1);
            checks++;
            if ({seg_b, dp_b, busy_b, done_b, ready_b} !== exp) begin
                failures++;
                $display("FAIL gap0 b=%h k=%0d got=%h exp=%h", b, k, {seg_b, dp_b, busy_b, done_b, ready_b}, exp);
            end
            step();
        end
    endtask

    task automatic test_rst_mid();
        logic [10:0] exp;
        logic [7:0]  b;
        b = 8'($urandom);
        accept_a(b);
        for (int k = 1; k <= 5; k++) begin
            exp = model(k, b, DA, GA, 1);
            checks++;
            if ({seg_a, dp_a, busy_a, done_a, ready_a} !== exp) begin
                failures++;
                $display("FAIL rst_mid_pre k=%0d got=%h exp=%h", k, {seg_a, dp_a, busy_a, done_a, ready_a}, exp);
            end
            if (k < 5) step();
        end
        rst = 1'b1; load_a = 1'b1; abort = 1'b1; data_in = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 1) begin rst = 1'b0; load_a = 1'b0; abort = 1'b0; end
            checks++;
            if ({seg_a, dp_a, busy_a, done_a, ready_a} !== IDLE_OUT) begin
                failures++;
                $display("FAIL rst_mid i=%0d got=%h exp=%h", i, {seg_a, dp_a, busy_a, done_a, ready_a}, IDLE_OUT);
            end
        end
    endtask

    // Load held high: each next byte is taken on the done cycle's edge.
    task automatic test_back_to_back();
        logic [10:0] exp;
        logic [7:0]  b;
        load_a = 1'b1;
        for (int n = 0; n < 3; n++) begin
            b = 8'($urandom);
            data_in = b;
            step();
            for (int k = 1; k <= 11; k++) begin
                exp = model(k, b, DA, GA, 1);
                checks++;
                if ({seg_a, dp_a, busy_a, done_a, ready_a} !== exp) begin
                    failures++;
                    $display("FAIL back_to_back n=%0d k=%0d got=%h exp=%h", n, k, {seg_a, dp_a, busy_a, done_a, ready_a}, exp);
                end
                if (k < 11) begin
                    data_in = 8'($urandom);
                    step();
                end
            end
        end
        load_a = 1'b0;
        step();
        step();
    endtask

    initial begin
        load_a = 1'b0; load_b = 1'b0; data_in = '0; repeat_en = 1'b0; abort = 1'b0; rst = 1'b0;
        test_reset();
        test_basic(8'hA7);
        test_load_ignored();
        test_repeat();
        test_abort();
        test_gap0(8'hE0);
        test_rst_mid();
        for (int n = 0; n < 16; n++) test_basic({4'(n), 4'(n)});
        for (int n = 0; n < 4; n++) test_basic(8'($urandom));
        for (int n = 0; n < 3; n++) test_gap0(8'($urandom));
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
